// File: rtl/ime_cost_accum.sv
// ime_cost_accum: accumulates per-row left/right SAD halves of one CU into
// four quadrant sums and, after the last row, presents the nine PU costs
// (NxN x4, 2NxN x2, Nx2N x2, 2Nx2N) plus a common MV bias, with a done strobe.
// Optional feature macro: IME_COST_SAT_EN (bias addition saturates instead of wrapping).
module ime_cost_accum #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned SAD_WIDTH   = PIXEL_WIDTH + 4,
    parameter int unsigned COST_WIDTH  = PIXEL_WIDTH + 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [1:0]            blk_size_i,
    input  logic [COST_WIDTH-1:0] bias_i,
    input  logic                  row_val_i,
    input  logic [SAD_WIDTH-1:0]  sad_l_i,
    input  logic [SAD_WIDTH-1:0]  sad_r_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [COST_WIDTH-1:0] cost_NxN_00_o,
    output logic [COST_WIDTH-1:0] cost_NxN_01_o,
    output logic [COST_WIDTH-1:0] cost_NxN_02_o,
    output logic [COST_WIDTH-1:0] cost_NxN_03_o,
    output logic [COST_WIDTH-1:0] cost_2NxN_0_o,
    output logic [COST_WIDTH-1:0] cost_2NxN_1_o,
    output logic [COST_WIDTH-1:0] cost_Nx2N_0_o,
    output logic [COST_WIDTH-1:0] cost_Nx2N_1_o,
    output logic [COST_WIDTH-1:0] cost_2Nx2N_o
);

    localparam int unsigned CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACCU = 2'd1,
        OUT  = 2'd2
    } fsmState_e;

    fsmState_e             state;
    logic [CNT_WIDTH-1:0]  rowCnt;
    logic [1:0]            sizeLat;
    logic [COST_WIDTH-1:0] biasLat;
    logic [COST_WIDTH-1:0] q00;
    logic [COST_WIDTH-1:0] q01;
    logic [COST_WIDTH-1:0] q02;
    logic [COST_WIDTH-1:0] q03;

    logic [CNT_WIDTH-1:0]  rowsM1;
    logic [CNT_WIDTH-1:0]  halfM1;
    logic                  rowAcc;
    logic                  lastRow;
    logic                  upperHalf;
    logic [COST_WIDTH-1:0] sadL;
    logic [COST_WIDTH-1:0] sadR;
    logic [COST_WIDTH-1:0] nq00;
    logic [COST_WIDTH-1:0] nq01;
    logic [COST_WIDTH-1:0] nq02;
    logic [COST_WIDTH-1:0] nq03;
    logic [COST_WIDTH-1:0] sumTop;
    logic [COST_WIDTH-1:0] sumBot;
    logic [COST_WIDTH-1:0] sumLeft;
    logic [COST_WIDTH-1:0] sumRight;
    logic [COST_WIDTH-1:0] sumAll;

    // Bias addition is the only operation that can exceed COST_WIDTH.
    function automatic logic [COST_WIDTH-1:0] addBias(
        input logic [COST_WIDTH-1:0] a,
        input logic [COST_WIDTH-1:0] b
    );
`ifdef IME_COST_SAT_EN
        logic [COST_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COST_WIDTH] ? {COST_WIDTH{1'b1}} : s[COST_WIDTH-1:0];
`else
        return a + b;
`endif
    endfunction

    // Row bookkeeping, next quadrant sums (including the row accepted this cycle) and partial sums.
    always_comb begin
        rowsM1    = CNT_WIDTH'(31);
        halfM1    = CNT_WIDTH'(15);
        rowAcc    = 1'b0;
        lastRow   = 1'b0;
        upperHalf = 1'b0;
        sadL      = COST_WIDTH'(sad_l_i);
        sadR      = COST_WIDTH'(sad_r_i);

        case (sizeLat)
            2'd0:    rowsM1 = CNT_WIDTH'(7);
            2'd1:    rowsM1 = CNT_WIDTH'(15);
            default: rowsM1 = CNT_WIDTH'(31);
        endcase
        halfM1    = rowsM1 >> 1;
        upperHalf = (rowCnt > halfM1);

        // start_i has priority: a row arriving together with start is dropped.
        rowAcc  = (state == ACCU) && row_val_i && !start_i;
        lastRow = rowAcc && (rowCnt == rowsM1);

        nq00 = q00;
        nq01 = q01;
        nq02 = q02;
        nq03 = q03;
        if (rowAcc) begin
            if (upperHalf) begin
                nq02 = q02 + sadL;
                nq03 = q03 + sadR;
            end else begin
                nq00 = q00 + sadL;
                nq01 = q01 + sadR;
            end
        end

        sumTop   = nq00 + nq01;
        sumBot   = nq02 + nq03;
        sumLeft  = nq00 + nq02;
        sumRight = nq01 + nq03;
        sumAll   = sumTop + sumBot;
    end

    // Control FSM, accumulators and registered cost outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rowCnt        <= '0;
            sizeLat       <= '0;
            biasLat       <= '0;
            q00           <= '0;
            q01           <= '0;
            q02           <= '0;
            q03           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            cost_NxN_00_o <= '0;
            cost_NxN_01_o <= '0;
            cost_NxN_02_o <= '0;
            cost_NxN_03_o <= '0;
            cost_2NxN_0_o <= '0;
            cost_2NxN_1_o <= '0;
            cost_Nx2N_0_o <= '0;
            cost_Nx2N_1_o <= '0;
            cost_2Nx2N_o  <= '0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                // New CU from any state; an unfinished CU is silently dropped.
                state   <= ACCU;
                busy_o  <= 1'b1;
                rowCnt  <= '0;
                sizeLat <= blk_size_i;
                biasLat <= bias_i;
                q00     <= '0;
                q01     <= '0;
                q02     <= '0;
                q03     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ACCU: begin
                        q00 <= nq00;
                        q01 <= nq01;
                        q02 <= nq02;
                        q03 <= nq03;
                        if (rowAcc) begin
                            rowCnt <= rowCnt + CNT_WIDTH'(1);
                        end
                        if (lastRow) begin
                            state         <= OUT;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                            cost_NxN_00_o <= addBias(nq00, biasLat);
                            cost_NxN_01_o <= addBias(nq01, biasLat);
                            cost_NxN_02_o <= addBias(nq02, biasLat);
                            cost_NxN_03_o <= addBias(nq03, biasLat);
                            cost_2NxN_0_o <= addBias(sumTop, biasLat);
                            cost_2NxN_1_o <= addBias(sumBot, biasLat);
                            cost_Nx2N_0_o <= addBias(sumLeft, biasLat);
                            cost_Nx2N_1_o <= addBias(sumRight, biasLat);
                            cost_2Nx2N_o  <= addBias(sumAll, biasLat);
                        end
                    end
                    OUT: begin
                        state <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ime_cost_accum.sv
// tb_ime_cost_accum: directed scenarios with hand-computed costs; expected
// cost vectors are queued at stimulus time and checked by a done_o monitor.
module tb_ime_cost_accum;

    localparam int unsigned PW = 8;
    localparam int unsigned SW = PW + 4;
    localparam int unsigned CW = PW + 12;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic [1:0]    blk_size_i;
    logic [CW-1:0] bias_i;
    logic          row_val_i;
    logic [SW-1:0] sad_l_i;
    logic [SW-1:0] sad_r_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] cost_NxN_00_o;
    logic [CW-1:0] cost_NxN_01_o;
    logic [CW-1:0] cost_NxN_02_o;
    logic [CW-1:0] cost_NxN_03_o;
    logic [CW-1:0] cost_2NxN_0_o;
    logic [CW-1:0] cost_2NxN_1_o;
    logic [CW-1:0] cost_Nx2N_0_o;
    logic [CW-1:0] cost_Nx2N_1_o;
    logic [CW-1:0] cost_2Nx2N_o;

    ime_cost_accum #(.PIXEL_WIDTH(PW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .blk_size_i    (blk_size_i),
        .bias_i        (bias_i),
        .row_val_i     (row_val_i),
        .sad_l_i       (sad_l_i),
        .sad_r_i       (sad_r_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .cost_NxN_00_o (cost_NxN_00_o),
        .cost_NxN_01_o (cost_NxN_01_o),
        .cost_NxN_02_o (cost_NxN_02_o),
        .cost_NxN_03_o (cost_NxN_03_o),
        .cost_2NxN_0_o (cost_2NxN_0_o),
        .cost_2NxN_1_o (cost_2NxN_1_o),
        .cost_Nx2N_0_o (cost_Nx2N_0_o),
        .cost_Nx2N_1_o (cost_Nx2N_1_o),
        .cost_2Nx2N_o  (cost_2Nx2N_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string              name;
        logic [8:0][CW-1:0] c;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   busyCnt = 0;

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Cost order: NxN 0..3, 2NxN 0..1, Nx2N 0..1, 2Nx2N.
    task automatic pushExp(input string name,
                           input int n0, input int n1, input int n2, input int n3,
                           input int h0, input int h1, input int v0, input int v1,
                           input int all);
        exp_t e;
        e.name = name;
        e.c[0] = CW'(n0); e.c[1] = CW'(n1); e.c[2] = CW'(n2); e.c[3] = CW'(n3);
        e.c[4] = CW'(h0); e.c[5] = CW'(h1); e.c[6] = CW'(v0); e.c[7] = CW'(v1);
        e.c[8] = CW'(all);
        expQ.push_back(e);
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t               e;
        logic [8:0][CW-1:0] act;
        busyCnt = busyCnt + (busy_o ? 1 : 0);
        if (rst_n && done_o) begin
            act = {cost_2Nx2N_o, cost_Nx2N_1_o, cost_Nx2N_0_o, cost_2NxN_1_o, cost_2NxN_0_o,
                   cost_NxN_03_o, cost_NxN_02_o, cost_NxN_01_o, cost_NxN_00_o};
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 required no pending CU");
            end else begin
                e = expQ.pop_front();
                for (int i = 0; i < 9; i++) begin
                    check($sformatf("%s.cost[%0d]", e.name, i), act[i], e.c[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startCu(input logic [1:0] size, input logic [CW-1:0] bias);
        start_i    = 1'b1;
        blk_size_i = size;
        bias_i     = bias;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic feedRow(input int l, input int r);
        row_val_i = 1'b1;
        sad_l_i   = SW'(l);
        sad_r_i   = SW'(r);
        tick();
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL %s.timeout: got %0d pending results required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkAllZero(input string name);
        check({name, ".busy"}, CW'(busy_o), '0);
        check({name, ".done"}, CW'(done_o), '0);
        check({name, ".nxn00"}, cost_NxN_00_o, '0);
        check({name, ".nxn01"}, cost_NxN_01_o, '0);
        check({name, ".nxn02"}, cost_NxN_02_o, '0);
        check({name, ".nxn03"}, cost_NxN_03_o, '0);
        check({name, ".2nxn0"}, cost_2NxN_0_o, '0);
        check({name, ".2nxn1"}, cost_2NxN_1_o, '0);
        check({name, ".nx2n0"}, cost_Nx2N_0_o, '0);
        check({name, ".nx2n1"}, cost_Nx2N_1_o, '0);
        check({name, ".2nx2n"}, cost_2Nx2N_o, '0);
    endtask

    task automatic run16(input string name);
        pushExp(name, 85, 165, 85, 165, 245, 245, 165, 325, 485);
        startCu(2'd1, CW'(5));
        busyCnt = 0;
        repeat (16) feedRow(10, 20);
        row_val_i = 1'b0;
        check({name, ".latency_done"}, CW'(done_o), CW'(1));
        waitDone(name);
        check({name, ".busy_cycles"}, CW'(busyCnt), CW'(16));
    endtask

    initial begin
        rst_n      = 1'b0;
        start_i    = 1'b0;
        blk_size_i = '0;
        bias_i     = '0;
        row_val_i  = 1'b0;
        sad_l_i    = '0;
        sad_r_i    = '0;
        repeat (3) tick();
        checkAllZero("reset");
        rst_n = 1'b1;
        tick();
        checkAllZero("idle");

        // 16x16 gapless
        run16("s16");

        // 8x8 with gaps, sad_l = r
        pushExp("gap8", 6, 4, 22, 4, 10, 26, 28, 8, 36);
        startCu(2'd0, '0);
        for (int r = 0; r < 8; r++) begin
            feedRow(r, 1);
            row_val_i = 1'b0;
            tick();
        end
        waitDone("gap8");

        // Abort a 32x32 CU after 10 rows, restart as 8x8
        startCu(2'd2, '0);
        repeat (10) feedRow(100, 100);
        row_val_i = 1'b0;
        pushExp("abort", 4, 4, 4, 4, 8, 8, 8, 8, 16);
        startCu(2'd0, '0);
        repeat (8) feedRow(1, 1);
        row_val_i = 1'b0;
        waitDone("abort");

        // Start and row together mid-CU: row is dropped
        startCu(2'd0, '0);
        repeat (3) feedRow(7, 7);
        pushExp("startrow", 4, 4, 4, 4, 8, 8, 8, 8, 16);
        row_val_i = 1'b1;
        sad_l_i   = SW'(500);
        sad_r_i   = SW'(500);
        startCu(2'd0, '0);
        repeat (8) feedRow(1, 1);
        row_val_i = 1'b0;
        waitDone("startrow");

        // Bias overflow
`ifdef IME_COST_SAT_EN
        pushExp("sat", 1048575, 1048575, 1048575, 1048575, 1048575, 1048575,
                1048575, 1048575, 1048575);
`else
        pushExp("wrap", 104, 104, 104, 104, 224, 224, 224, 224, 464);
`endif
        startCu(2'd0, CW'(1048560));
        repeat (8) feedRow(30, 30);
        row_val_i = 1'b0;
        waitDone("bias_ovf");

        // Costs hold across a new start
        startCu(2'd1, '0);
`ifdef IME_COST_SAT_EN
        check("hold.2nx2n", cost_2Nx2N_o, CW'(1048575));
`else
        check("hold.2nx2n", cost_2Nx2N_o, CW'(464));
`endif
        check("hold.busy", CW'(busy_o), CW'(1));

        // Reset mid-CU
        repeat (5) feedRow(10, 20);
        row_val_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        run16("after_reset");

        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending results required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
